// File: rtl/mips_execute_unit.sv
// Execute stage of the 5-stage MIPS pipeline: ALU control decode, 32-bit ALU,
// branch-target adder and jump override, registered at the EX/MEM boundary.
module mips_execute_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm_ext,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] jump_addr,
    input  logic [5:0]  opcode,
    input  logic [1:0]  alu_op,
    input  logic        alu_src,
    input  logic        jump,
    output logic [3:0]  alu_cnt,
    output logic [31:0] result_q,
    output logic        zero_q,
    output logic [31:0] branch_target_q,
    output logic [31:0] store_data_q
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_AND = 4'b0000;
    localparam logic [CNT_W-1:0] CNT_OR  = 4'b0001;
    localparam logic [CNT_W-1:0] CNT_ADD = 4'b0010;
    localparam logic [CNT_W-1:0] CNT_SUB = 4'b0110;
    localparam logic [CNT_W-1:0] CNT_SLT = 4'b0111;
    localparam logic [CNT_W-1:0] CNT_NOR = 4'b1100;

    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] result_next;
    logic              zero;

    // ALU control decode from the main-control class, funct or opcode
    always_comb begin
        alu_cnt = CNT_ADD;
        case (alu_op)
            2'b00: alu_cnt = CNT_ADD;
            2'b01: alu_cnt = CNT_SUB;
            2'b10: begin
                case (imm_ext[5:0])
                    6'b100000: alu_cnt = CNT_ADD;
                    6'b100010: alu_cnt = CNT_SUB;
                    6'b100100: alu_cnt = CNT_AND;
                    6'b100101: alu_cnt = CNT_OR;
                    6'b101010: alu_cnt = CNT_SLT;
                    6'b100111: alu_cnt = CNT_NOR;
                    default:   alu_cnt = CNT_ADD;
                endcase
            end
            default: begin
                case (opcode)
                    6'b001000: alu_cnt = CNT_ADD;
                    6'b001100: alu_cnt = CNT_AND;
                    6'b001101: alu_cnt = CNT_OR;
                    6'b001010: alu_cnt = CNT_SLT;
                    default:   alu_cnt = CNT_ADD;
                endcase
            end
        endcase
    end

    assign operand_b = alu_src ? imm_ext : rt_data;

    // ALU; unused control codes yield zero
    always_comb begin
        alu_result = '0;
        case (alu_cnt)
            CNT_AND: alu_result = rs_data & operand_b;
            CNT_OR:  alu_result = rs_data | operand_b;
            CNT_ADD: alu_result = rs_data + operand_b;
            CNT_SUB: alu_result = rs_data - operand_b;
            CNT_SLT: alu_result = ($signed(rs_data) < $signed(operand_b)) ? DATA_W'(1) : '0;
            CNT_NOR: alu_result = ~(rs_data | operand_b);
            default: alu_result = '0;
        endcase
    end

    // Zero flag always reflects the ALU, even when the jump target is selected
    assign zero          = (alu_result == '0);
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign result_next   = jump ? jump_addr : alu_result;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            result_q        <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            store_data_q    <= '0;
        end else begin
            result_q        <= result_next;
            zero_q          <= zero;
            branch_target_q <= branch_target;
            store_data_q    <= rt_data;
        end
    end

endmodule

// File: tb/tb_mips_execute_unit.sv
// Self-checking bench for mips_execute_unit: directed scenarios plus randomized
// traffic checked against a behavioural model of the execute stage.
module tb_mips_execute_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] rs_data = '0, rt_data = '0, imm_ext = '0, pc_plus4 = '0, jump_addr = '0;
    logic [5:0]  opcode = '0;
    logic [1:0]  alu_op = '0;
    logic        alu_src = 1'b0, jump = 1'b0;
    logic [3:0]  alu_cnt;
    logic [31:0] result_q, branch_target_q, store_data_q;
    logic        zero_q;

    int checks = 0;
    int passed = 0;

    mips_execute_unit dut (
        .Clk(Clk), .Rst(Rst), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .pc_plus4(pc_plus4), .jump_addr(jump_addr), .opcode(opcode), .alu_op(alu_op),
        .alu_src(alu_src), .jump(jump), .alu_cnt(alu_cnt), .result_q(result_q),
        .zero_q(zero_q), .branch_target_q(branch_target_q), .store_data_q(store_data_q)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: instruction -> operation name -> value
    function automatic string op_name(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] opc);
        if (op == 2'b00) return "add";
        if (op == 2'b01) return "sub";
        if (op == 2'b10) begin
            if (fn == 6'd32) return "add";
            if (fn == 6'd34) return "sub";
            if (fn == 6'd36) return "and";
            if (fn == 6'd37) return "or";
            if (fn == 6'd42) return "slt";
            if (fn == 6'd39) return "nor";
            return "add";
        end
        if (opc == 6'd8)  return "add";
        if (opc == 6'd12) return "and";
        if (opc == 6'd13) return "or";
        if (opc == 6'd10) return "slt";
        return "add";
    endfunction

    function automatic logic [3:0] code_of(input string n);
        if (n == "and") return 4'd0;
        if (n == "or")  return 4'd1;
        if (n == "sub") return 4'd6;
        if (n == "slt") return 4'd7;
        if (n == "nor") return 4'd12;
        return 4'd2;
    endfunction

    function automatic logic [31:0] eval(input string n, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (n == "and") return a & b;
        if (n == "or")  return a | b;
        if (n == "nor") return ~(a | b);
        if (n == "sub") return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
        if (n == "slt") return (sa < sb) ? 32'd1 : 32'd0;
        return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    endfunction

    task automatic set_in(input logic [1:0] op, input logic [5:0] opc, input logic src, input logic j,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [31:0] ja);
        alu_op = op; opcode = opc; alu_src = src; jump = j;
        rs_data = rs; rt_data = rt; imm_ext = imm; pc_plus4 = pc; jump_addr = ja;
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        @(posedge Clk); #1;
        set_in(2'b00, 6'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd1, 32'h200, 32'h0);
        Rst = 1'b0;
        step();
        checks++; if (result_q !== 32'd7) $display("FAIL reset_first_capture result_q got %h want %h", result_q, 32'd7); else passed++;
        checks++; if (branch_target_q !== 32'h204) $display("FAIL reset_first_capture branch got %h want %h", branch_target_q, 32'h204); else passed++;
        Rst = 1'b1;
        #1;
        checks++; if (result_q !== 32'd0) $display("FAIL reset_async result_q got %h want 0", result_q); else passed++;
        checks++; if (branch_target_q !== 32'd0) $display("FAIL reset_async branch got %h want 0", branch_target_q); else passed++;
        checks++; if (store_data_q !== 32'd0) $display("FAIL reset_async store got %h want 0", store_data_q); else passed++;
        step();
        checks++; if (result_q !== 32'd0 || zero_q !== 1'b0) $display("FAIL reset_hold result_q got %h zero %b want 0/0", result_q, zero_q); else passed++;
        Rst = 1'b0;
        step();
        checks++; if (store_data_q !== 32'd4) $display("FAIL reset_release store got %h want 4", store_data_q); else passed++;
    endtask

    task automatic test_rtype;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'd7, 32'd5, 32'h20, 32'h0, 32'h0);
        #1;
        checks++; if (alu_cnt !== 4'b0010) $display("FAIL rtype_add alu_cnt got %b want 0010", alu_cnt); else passed++;
        step();
        checks++; if (result_q !== 32'd12 || zero_q !== 1'b0) $display("FAIL rtype_add got %h/%b want c/0", result_q, zero_q); else passed++;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'd9, 32'd9, 32'h22, 32'h0, 32'h0);
        step();
        checks++; if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL rtype_sub got %h/%b want 0/1", result_q, zero_q); else passed++;
    endtask

    task automatic test_logic;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h0, 32'h0);
        step();
        checks++; if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL add_wrap got %h/%b want 0/1", result_q, zero_q); else passed++;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h24, 32'h0, 32'h0);
        step();
        checks++; if (result_q !== 32'h00F000F0) $display("FAIL and got %h want 00f000f0", result_q); else passed++;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h27, 32'h0, 32'h0);
        #1;
        checks++; if (alu_cnt !== 4'b1100) $display("FAIL nor alu_cnt got %b want 1100", alu_cnt); else passed++;
        step();
        checks++; if (result_q !== 32'hFFFFFFFF || zero_q !== 1'b0) $display("FAIL nor got %h/%b want ffffffff/0", result_q, zero_q); else passed++;
    endtask

    task automatic test_slt;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 32'h2A, 32'h0, 32'h0);
        step();
        checks++; if (result_q !== 32'd1) $display("FAIL slt_neg_lt got %h want 1", result_q); else passed++;
        set_in(2'b10, 6'd0, 1'b0, 1'b0, 32'd3, 32'hFFFFFFFE, 32'h2A, 32'h0, 32'h0);
        step();
        checks++; if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL slt_pos_ge got %h/%b want 0/1", result_q, zero_q); else passed++;
    endtask

    task automatic test_itype_branch;
        set_in(2'b11, 6'b001101, 1'b1, 1'b0, 32'h00000F00, 32'h12345678, 32'h000000FF, 32'h100, 32'h0);
        #1;
        checks++; if (alu_cnt !== 4'b0001) $display("FAIL ori alu_cnt got %b want 0001", alu_cnt); else passed++;
        step();
        checks++; if (result_q !== 32'h00000FFF) $display("FAIL ori got %h want 00000fff", result_q); else passed++;
        set_in(2'b01, 6'd4, 1'b0, 1'b0, 32'd1, 32'd2, 32'hFFFFFFFF, 32'h100, 32'h0);
        step();
        checks++; if (branch_target_q !== 32'hFC) $display("FAIL branch_back got %h want fc", branch_target_q); else passed++;
    endtask

    task automatic test_jump;
        set_in(2'b00, 6'd2, 1'b0, 1'b1, 32'd1, 32'd1, 32'h0, 32'h0, 32'h00400020);
        step();
        checks++; if (result_q !== 32'h00400020) $display("FAIL jump result got %h want 00400020", result_q); else passed++;
        checks++; if (zero_q !== 1'b0) $display("FAIL jump zero got %b want 0", zero_q); else passed++;
        checks++; if (store_data_q !== 32'd1) $display("FAIL jump store got %h want 1", store_data_q); else passed++;
    endtask

    task automatic test_random;
        logic [5:0] fns [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};
        logic [5:0] opcs[6] = '{6'd8, 6'd12, 6'd13, 6'd10, 6'd4, 6'd35};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b, imm, pc, ja, bsel, exp_res, exp_bt;
            logic [1:0] op;
            logic [5:0] opc;
            logic src, j;
            string n;
            op = 2'($urandom_range(0, 3));
            opc = opcs[$urandom_range(0, 5)];
            src = 1'($urandom);
            j = ($urandom_range(0, 7) == 0);
            a = $urandom; b = $urandom; pc = $urandom; ja = $urandom;
            imm = {$urandom} & 32'hFFFF_FFC0 | 32'(fns[$urandom_range(0, 7)]);
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) imm = {{16{imm[15]}}, imm[15:0]};
            set_in(op, opc, src, j, a, b, imm, pc, ja);
            n = op_name(op, imm[5:0], opc);
            bsel = src ? imm : b;
            exp_res = eval(n, a, bsel);
            exp_bt = 32'((64'(pc) + 64'(imm) * 64'd4) % 64'h1_0000_0000);
            #1;
            checks++; if (alu_cnt !== code_of(n)) $display("FAIL rand%0d alu_cnt got %b want %b", i, alu_cnt, code_of(n)); else passed++;
            step();
            checks++; if (result_q !== (j ? ja : exp_res)) $display("FAIL rand%0d result got %h want %h", i, result_q, j ? ja : exp_res); else passed++;
            checks++; if (zero_q !== (exp_res == 32'd0)) $display("FAIL rand%0d zero got %b want %b", i, zero_q, exp_res == 32'd0); else passed++;
            checks++; if (branch_target_q !== exp_bt) $display("FAIL rand%0d branch got %h want %h", i, branch_target_q, exp_bt); else passed++;
            checks++; if (store_data_q !== b) $display("FAIL rand%0d store got %h want %h", i, store_data_q, b); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_logic();
        test_slt();
        test_itype_branch();
        test_jump();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
